// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 Hz raster constants, sync windows, colour fields and
// the small helpers shared by the VGA controller and its delay line.
`timescale 1ns/1ps
package vga_pkg;

  // Horizontal geometry, in pixel-clock cycles
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;

  // Vertical geometry, in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  // Whole line / whole frame
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // First and last counter value of each sync pulse (inclusive)
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Renderer latency used by the page renderers
  localparam int PIX_LAT_DEFAULT = 1;

  // Counter and pixel widths
  localparam int CNT_W = 10;
  localparam int PIX_W = 12;

  // Colour fields inside pixel_data, laid out as {B,G,R}
  localparam int R_LSB = 0;
  localparam int R_MSB = 3;
  localparam int G_LSB = 4;
  localparam int G_MSB = 7;
  localparam int B_LSB = 8;
  localparam int B_MSB = 11;

  // Raster-stage attributes that travel alongside the pixel request
  typedef struct packed {
    logic act;
    logic hsN;
    logic vsN;
  } syncBits_t;

  // Blanked, both syncs released
  localparam syncBits_t SYNC_IDLE = '{act: 1'b0, hsN: 1'b1, vsN: 1'b1};

  // First counter value of a sync pulse for a given active/porch split
  function automatic logic [CNT_W-1:0] syncFirst(input int active, input int porch);
    return CNT_W'(active + porch);
  endfunction

  // Last counter value of a sync pulse for a given active/porch/width split
  function automatic logic [CNT_W-1:0] syncLast(input int active, input int porch,
                                                 input int width);
    return CNT_W'(active + porch + width - 1);
  endfunction

  // Inclusive range test on a raster counter
  function automatic logic inRange(input logic [CNT_W-1:0] value,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: WIDTH x DEPTH shift register that lines raster attributes
// up with pixel data returned by the renderers. Reset flushes every tap to IDLE.
`timescale 1ns/1ps
module vga_sync_delay #(
  parameter int              WIDTH = 3,
  parameter int              DEPTH = 1,
  parameter logic [WIDTH-1:0] IDLE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  import vga_pkg::*;

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one tap per clock; reset fills the whole line with the idle pattern
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= IDLE;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl: raster timing generator and registered VGA output stage.
// Coordinates go out to the renderers straight from the counters; the
// matching blanking and sync bits are delayed by PIX_LAT so they meet the
// returned pixel, and everything is registered once more onto the pins.
`timescale 1ns/1ps
module vga_ctrl #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int PIX_LAT  = vga_pkg::PIX_LAT_DEFAULT
) (
  input  logic        vga_clk,
  input  logic        vga_rst,
  input  logic [11:0] pixel_data,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);
  import vga_pkg::*;

  // Counter-width versions of the geometry so every compare is 10 bits wide
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST  = syncFirst(H_ACTIVE, H_FP);
  localparam logic [CNT_W-1:0] HS_LAST   = syncLast(H_ACTIVE, H_FP, H_SYNC);
  localparam logic [CNT_W-1:0] VS_FIRST  = syncFirst(V_ACTIVE, V_FP);
  localparam logic [CNT_W-1:0] VS_LAST   = syncLast(V_ACTIVE, V_FP, V_SYNC);

  logic [CNT_W-1:0] hCnt_q, hCnt_d;
  logic [CNT_W-1:0] vCnt_q, vCnt_d;
  logic             hWrap;

  syncBits_t rasterBits;
  syncBits_t delayedBits;

  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic [3:0] r_q, r_d;
  logic [3:0] g_q, g_d;
  logic [3:0] b_q, b_d;

  // Next raster position: h wraps every line, v advances only on that wrap
  always_comb begin
    hWrap  = (hCnt_q == H_LAST);
    hCnt_d = hWrap ? '0 : hCnt_q + 10'd1;
    vCnt_d = vCnt_q;
    if (hWrap) begin
      vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 10'd1;
    end
  end

  // Raster counters; reset parks them at the top-left corner
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      hCnt_q <= '0;
      vCnt_q <= '0;
    end else begin
      hCnt_q <= hCnt_d;
      vCnt_q <= vCnt_d;
    end
  end

  // Blanking and sync attributes of the position currently being requested
  always_comb begin
    rasterBits     = SYNC_IDLE;
    rasterBits.act = (hCnt_q < H_ACT_END) && (vCnt_q < V_ACT_END);
    rasterBits.hsN = !inRange(hCnt_q, HS_FIRST, HS_LAST);
    rasterBits.vsN = !inRange(vCnt_q, VS_FIRST, VS_LAST);
  end

  // Renderers derive memory addresses from these, so blank positions read as 0
  assign x_pos = (hCnt_q < H_ACT_END) ? hCnt_q : '0;
  assign y_pos = (vCnt_q < V_ACT_END) ? vCnt_q : '0;

  // Held low during reset so listeners see exactly one pulse after release
  assign frame_start = !vga_rst && (hCnt_q == '0) && (vCnt_q == '0);

  // Hold the attributes back by the renderer latency so they meet pixel_data
  vga_sync_delay #(
    .WIDTH ($bits(syncBits_t)),
    .DEPTH (PIX_LAT),
    .IDLE  (SYNC_IDLE)
  ) uSyncDelay (
    .clk_i (vga_clk),
    .rst_i (vga_rst),
    .d_i   (rasterBits),
    .q_o   (delayedBits)
  );

  // Pin values for the next clock: colour only inside the visible window
  always_comb begin
    hs_d = delayedBits.hsN;
    vs_d = delayedBits.vsN;
    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    if (delayedBits.act) begin
      r_d = pixel_data[R_MSB:R_LSB];
      g_d = pixel_data[G_MSB:G_LSB];
      b_d = pixel_data[B_MSB:B_LSB];
    end
  end

  // Registered VGA pins; reset shows idle blanking with both syncs released
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
    end
  end

  assign vga_hs = hs_q;
  assign vga_vs = vs_q;
  assign vga_r  = r_q;
  assign vga_g  = g_q;
  assign vga_b  = b_q;

endmodule

// File: doc/vga_ctrl.md
Name: vga_ctrl

Overview:
Timing generator and output stage for the 640x480@60 Hz display path, clocked by the 25 MHz pixel clock. It produces the raster coordinates (x_pos, y_pos) that drive the page renderers and accepts their 12-bit pixel_data after a fixed latency. It realigns hsync, vsync and blanking to that returned data and drives the registered VGA pins. It also emits a frame_start pulse for page and key-handling logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch in cycles
H_SYNC, 96, hsync pulse width in cycles
H_BP, 48, horizontal back porch in cycles
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vsync pulse width in lines
V_BP, 33, vertical back porch in lines
PIX_LAT, 1, cycles from x_pos/y_pos to valid pixel_data (page renderers = 1); legal range 1..4

Ports:
vga_clk  in  1  pixel clock, 25 MHz
vga_rst  in  1  reset
pixel_data  in  12  pixel from the page renderer, format {B[3:0],G[3:0],R[3:0]}
x_pos  out  10  requested column, 0..639
y_pos  out  10  requested row, 0..479
frame_start  out  1  one-cycle pulse when the raster counter is at (0,0)
vga_hs  out  1  horizontal sync, active low
vga_vs  out  1  vertical sync, active low
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue

Interface timing: one clock (vga_clk). Reset (vga_rst) is synchronous and active-high.

Behaviour:
- Derived totals: H_TOTAL = 800 cycles per line, V_TOTAL = 525 lines per frame, 420000 cycles per frame.
- Raster counters h_cnt (10 b) and v_cnt (10 b):
  - h_cnt increments every cycle and wraps H_TOTAL-1 -> 0.
  - v_cnt increments only on the h_cnt wrap and wraps V_TOTAL-1 -> 0 on that same cycle.
- Counter stage, combinational from the counters:
  - act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs_n = 0 when h_cnt is in 656..751
  - vs_n = 0 when v_cnt is in 490..491
- x_pos = h_cnt when h_cnt < H_ACTIVE, else 0. y_pos = v_cnt when v_cnt < V_ACTIVE, else 0. Both are driven directly from the counters.
  - Out-of-range coordinates are never presented, because renderers compute addresses from them.
- frame_start = 1 exactly when h_cnt == 0 and v_cnt == 0. It is driven directly from the counters.
- Alignment delay line: {act, hs_n, vs_n} pass through a PIX_LAT-deep shift register.
  - Reset contents: act = 0, hs_n = 1, vs_n = 1.
- Output registers:
  - vga_hs and vga_vs take the delayed hs_n/vs_n.
  - When delayed act = 1: vga_r = pixel_data[3:0], vga_g = pixel_data[7:4], vga_b = pixel_data[11:8].
  - When delayed act = 0: RGB = 0.
- Latency: a coordinate presented at cycle t appears on the pins at t+PIX_LAT+1. Sync pulses get the identical delay, so timing relative to RGB is exact.
- Reset, applied on any cycle including mid-frame, takes effect at the next edge:
  - h_cnt = v_cnt = 0; delay line flushed to idle.
  - vga_hs = 1, vga_vs = 1, RGB = 0, frame_start = 0.
  - frame_start is suppressed while vga_rst is high. It first pulses on the first cycle after release, since the counter is then at (0,0).
- On release, the first valid RGB appears PIX_LAT+1 cycles later. Until then the pins show idle blanking.
- No backpressure: pixel_data is sampled blindly at the fixed latency.

Decomposition:
- Package vga_pkg holds:
  - the eight timing constants and the derived H_TOTAL/V_TOTAL;
  - sync start/end constants;
  - colour field bit ranges (R 3:0, G 7:4, B 11:8).
- One sub-module, vga_sync_delay: a parameterised width x depth shift register with synchronous reset to a parameterised idle value. It is used for the {act, hs_n, vs_n} alignment line.

Test Plan:
1. Hold vga_rst for 3 cycles, then release.
   -> On the first cycle after release: x_pos = 0, y_pos = 0, frame_start = 1.
   -> vga_hs = vga_vs = 1 and RGB = 0 until cycle PIX_LAT+1.
2. Run 1 line.
   -> x_pos counts 0..639, then holds 0 for 160 cycles.
   -> y_pos steps 0 -> 1 at cycle 800.
   -> vga_hs is low for exactly 96 cycles, starting at line cycle 656+PIX_LAT+1 = 658.
3. Run 2 frames.
   -> frame_start pulses are exactly 420000 cycles apart.
   -> vga_vs is low for exactly 1600 cycles, starting 490*800+2 cycles after frame_start.
4. Model pixel source with 1-cycle latency returning {x[3:0], y[3:0], x[7:4]}.
   -> At every active pin cycle: vga_b = x[3:0], vga_g = y[3:0], vga_r = x[7:4] of the matching coordinate.
   -> Blank cycles have RGB = 0.
5. Drive pixel_data = 12'hFFF constantly.
   -> RGB is 4'hF only inside the 640x480 window.
   -> Outside the window, including during both porches, RGB = 0.
6. Assert vga_rst for 1 cycle at v_cnt = 200, h_cnt = 300.
   -> Next cycle: x_pos = 0, y_pos = 0, vga_hs = vga_vs = 1, RGB = 0.
   -> frame_start pulses on the first cycle after vga_rst deasserts.
